bcd_to_bin_seq: RTL and testbench
=================================

Name: bcd_to_bin_seq

Overview:
- Sequential BCD-to-binary converter; the inverse of convert_to_bcd.
- Accepts a packed DIGITS-digit BCD word over a valid/ready handshake.
- Accumulates one digit per clock, MSD first: acc = acc*10 + digit.
- Presents the binary result over a valid/ready handshake.
- Sits between BCD sources (keypad, display registers) and the binary datapath. Flags non-decimal nibbles.

Parameters:
- DIGITS, default 4: number of BCD digits; bcd_in width is 4*DIGITS.
- OUT_W, default 14: binary output width; must be >= ceil(log2(10^DIGITS)) (14 for 4 digits).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- bcd_in  input  4*DIGITS  packed BCD; [3:0] is units, [4*DIGITS-1:4*DIGITS-4] is the MSD.
- in_valid  input  1  bcd_in is valid.
- in_ready  output  1  block can accept input.
- bin_out  output  OUT_W  binary result.
- err  output  1  the accepted word contained a nibble > 9.
- out_valid  output  1  bin_out/err are valid.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- Reset values: state IDLE, in_ready=1, out_valid=0, bin_out=0, err=0, acc=0, digit index=0.
- rst asserted mid-conversion or while DONE aborts immediately to the reset values. The pending result is discarded and is never presented.

State IDLE:
- in_ready=1.
- Input handshake = in_valid & in_ready at a rising edge. On handshake: latch bcd_in into a shift register, clear acc, in_ready drops.
- If any latched nibble > 9, go to DONE with bin_out=0, err=1. Result is visible one cycle after the handshake edge.
- Otherwise go to CONV.

State CONV:
- Lasts exactly DIGITS cycles. in_ready=0.
- Each cycle: acc <= (acc<<3) + (acc<<1) + top nibble; shift register shifts left by 4.
- The multiply-by-10 uses shift/add only; no multiplier inference.
- Arithmetic is OUT_W bits wide; with a legal OUT_W no overflow is possible.
- After the DIGITS-th update: bin_out <= acc result, err <= 0, go to DONE.
- out_valid rises DIGITS cycles after the handshake edge (4 for the defaults).

State DONE:
- out_valid=1, in_ready=0. bin_out and err are held stable.
- On out_valid & out_ready at an edge: out_valid falls, go to IDLE, in_ready=1 next cycle.
- bin_out and err keep their last values after the transfer; they are don't-care while out_valid=0.

Boundary conditions:
- in_valid while not in IDLE is ignored; no queuing; bcd_in changes are ignored.
- out_ready while out_valid=0 is ignored.
- No same-cycle in/out overlap: minimum spacing between input handshakes is DIGITS+2 cycles for valid words and 3 cycles for invalid ones.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- bcd_in=16'h0000, in_valid pulse, out_ready=1 -> bin_out=0, err=0, out_valid exactly 4 cycles after the handshake edge for one cycle.
- bcd_in=16'h9999 -> bin_out=9999 (14'h270F), err=0. Then bcd_in=16'h1234 -> bin_out=1234 (14'h04D2).
- bcd_in=16'h12A4 -> err=1, bin_out=0, out_valid 1 cycle after the handshake. Also bcd_in=16'hF000 -> err=1.
- Backpressure: bcd_in=16'h0042, out_ready=0 for 6 cycles -> out_valid and bin_out=42 held stable, in_ready=0. in_valid with 16'h0001 during this window is ignored. out_ready=1 -> single transfer, then in_ready=1.
- Reset mid-conversion: assert rst 2 cycles after accepting 16'h5678 -> all outputs at reset values immediately. After release, 16'h0007 -> bin_out=7 with no stale result emitted.
- Round-trip sweep: binary 0..9999 -> convert_to_bcd -> this block -> bin_out equals the original for every value, err never set.

Source files
------------

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter.
// Accepts one BCD word, folds in one digit per clock (MSD first, acc = acc*10 + digit)
// and presents the binary result, or an error flag for non-decimal nibbles.
module bcd_to_bin_seq #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned OUT_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [OUT_W-1:0]      bin_out,
    output logic                  err,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   shreg_q, shreg_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   bin_out_q, bin_out_d;
    logic               err_q, err_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    logic               bad_c;
    logic [OUT_W-1:0]   acc_next_c;

    // Times ten by shift/add, then add the current most-significant digit.
    assign acc_next_c = (acc_q << 3) + (acc_q << 1) + OUT_W'(shreg_q[BCD_W-1 -: 4]);

    // Flag any non-decimal nibble in the latched word.
    always_comb begin
        bad_c = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (shreg_q[4*i +: 4] > 4'd9) begin
                bad_c = 1'b1;
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        bin_out_d   = bin_out_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    shreg_d    = bcd_in;
                    acc_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = CONV;
                end
            end
            CONV: begin
                // The latched word is validated on the first conversion cycle.
                if ((cnt_q == '0) && bad_c) begin
                    bin_out_d   = '0;
                    err_d       = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    acc_d   = acc_next_c;
                    shreg_d = shreg_q << 4;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        bin_out_d   = acc_next_c;
                        err_d       = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            bin_out_q   <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            bin_out_q   <= bin_out_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bin_out   = bin_out_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Randomized self-checking bench for bcd_to_bin_seq against a digit-weight reference model.
module tb_bcd_to_bin_seq;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned OUT_W  = 14;

    logic                clk = 1'b0;
    logic                rst;
    logic [4*DIGITS-1:0] bcd_in;
    logic                in_valid;
    logic                in_ready;
    logic [OUT_W-1:0]    bin_out;
    logic                err;
    logic                out_valid;
    logic                out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    bcd_to_bin_seq #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bcd_in    (bcd_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_out   (bin_out),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Reference: weighted digit sum; any nibble above 9 yields err with a zero result.
    task automatic ref_model(input logic [15:0] w, output logic [31:0] exp_bin, output logic exp_err);
        int val;
        int pw;
        int d;
        val = 0;
        pw  = 1;
        exp_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'((w >> (4 * i)) & 16'hF);
            if (d > 9) exp_err = 1'b1;
            val += d * pw;
            pw  *= 10;
        end
        exp_bin = exp_err ? 32'd0 : 32'(val);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
        end
        return r;
    endfunction

    // One full transaction: handshake, latency, result, optional backpressure, transfer.
    task automatic run_word(input logic [15:0] w, input int hold, input bit poke);
        int          cyc;
        int          exp_lat;
        logic [31:0] exp_bin;
        logic        exp_err;
        logic [OUT_W-1:0] held;
        ref_model(w, exp_bin, exp_err);
        exp_lat = exp_err ? 1 : DIGITS;
        @(negedge clk);
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("in_ready_idle", 32'(in_ready), 32'd1);
        bcd_in    = w;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        bcd_in   = 16'($urandom);
        check("in_ready_busy", 32'(in_ready), 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(exp_lat));
        check("bin_out", 32'(bin_out), exp_bin);
        check("err", 32'(err), 32'(exp_err));
        if (hold > 0) begin
            held = bin_out;
            for (int i = 0; i < hold; i++) begin
                if (poke && i == 1) begin
                    in_valid = 1'b1;
                    bcd_in   = 16'h0001;
                end
                @(posedge clk);
                #1;
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_bin", 32'(bin_out), 32'(held));
                check("hold_in_ready", 32'(in_ready), 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        bcd_in    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_bin_out", 32'(bin_out), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        run_word(16'h0000, 0, 1'b0);
        run_word(16'h9999, 0, 1'b0);
        run_word(16'h1234, 0, 1'b0);
        run_word(16'h12A4, 0, 1'b0);
        run_word(16'hF000, 0, 1'b0);
        run_word(16'h0042, 6, 1'b1);
        run_word(16'h0009, 0, 1'b0);

        // Reset two cycles into a conversion.
        @(negedge clk);
        bcd_in   = 16'h5678;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_bin_out", 32'(bin_out), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) cyc++;
        end
        check("no_stale_result", 32'(cyc), 32'd0);
        run_word(16'h0007, 0, 1'b0);

        // Round-trip sweep over binary values through a BCD encoding.
        for (int v = 0; v < 10000; v += 7) begin
            run_word(to_bcd(v), 0, 1'b0);
        end
        run_word(to_bcd(99), 0, 1'b0);
        run_word(to_bcd(100), 0, 1'b0);
        run_word(to_bcd(1000), 0, 1'b0);
        run_word(to_bcd(9999), 0, 1'b0);

        // Random words, legal and illegal, with random backpressure.
        for (int k = 0; k < 300; k++) begin
            run_word(16'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
